pwm_pitch_meter: RTL and testbench

Measurement block for the synthesizer's audio path. It watches a PWM/square-wave signal such as `pwm_o` from `synth_top`, and measures the period and high time of each cycle in clock cycles. It reports each completed measurement with a single-cycle valid strobe and flags loss of signal. It is used on-chip for self-test of note pitch and duty, and in benches as the checker for the synth output.

---
 rtl/pwm_pitch_meter.sv | 117 +++++++++++
 tb/tb_pwm_pitch_meter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pwm_pitch_meter.sv
// Measures period and high time of a square wave in clk cycles, with a one-cycle
// valid strobe per completed period and an idle flag for missing or lost signal.
module pwm_pitch_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             pwm_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             idle_o
);

    localparam logic [1:0] WAIT_FIRST = 2'd0;
    localparam logic [1:0] MEASURE    = 2'd1;
    localparam logic [1:0] TIMEOUT    = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s1_r;
    logic             s2_r;
    logic             s3_r;
    logic             rise_s;
    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] hcnt_s;
    logic [CNT_W-1:0] period_s;
    logic [CNT_W-1:0] high_s;
    logic             valid_s;
    logic             idle_s;

    assign rise_s = s2_r & ~s3_r;

    // Two-stage synchronizer plus one delay stage for rising-edge detection.
    always_ff @(posedge clk) begin
        if (RST) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= pwm_i;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Next-state, counter and output update logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        hcnt_s   = hcnt_r;
        period_s = period_o;
        high_s   = high_o;
        valid_s  = 1'b0;
        idle_s   = idle_o;
        case (state_r)
            WAIT_FIRST, TIMEOUT: begin
                // Entering MEASURE keeps idle high until the first full period is reported.
                idle_s = 1'b1;
                if (rise_s) begin
                    cnt_s   = CNT_ONE;
                    hcnt_s  = CNT_ONE;
                    state_s = MEASURE;
                end else begin
                    state_s = state_r;
                end
            end
            MEASURE: begin
                if (rise_s) begin
                    period_s = cnt_r;
                    high_s   = hcnt_r;
                    valid_s  = 1'b1;
                    idle_s   = 1'b0;
                    cnt_s    = CNT_ONE;
                    hcnt_s   = CNT_ONE;
                end else if (cnt_r == CNT_MAX) begin
                    state_s = TIMEOUT;
                    idle_s  = 1'b1;
                end else begin
                    cnt_s  = cnt_r + CNT_ONE;
                    hcnt_s = hcnt_r + {{(CNT_W-1){1'b0}}, s2_r};
                end
            end
            default: begin
                state_s = WAIT_FIRST;
                idle_s  = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r  <= WAIT_FIRST;
            cnt_r    <= {CNT_W{1'b0}};
            hcnt_r   <= {CNT_W{1'b0}};
            period_o <= {CNT_W{1'b0}};
            high_o   <= {CNT_W{1'b0}};
            valid_o  <= 1'b0;
            idle_o   <= 1'b1;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            hcnt_r   <= hcnt_s;
            period_o <= period_s;
            high_o   <= high_s;
            valid_o  <= valid_s;
            idle_o   <= idle_s;
        end
    end

endmodule

// File: tb/tb_pwm_pitch_meter.sv
// Scoreboard bench for pwm_pitch_meter; counter width reduced to 12 bits so the
// timeout and full-range period cases stay short (timeout after 4095 cycles).
module tb_pwm_pitch_meter;

    localparam int W = 12;
    localparam int TMAX = (1 << W) - 1;

    logic         tb_clk = 1'b0;
    logic         RST = 1'b1;
    logic         pwm_i = 1'b0;
    logic [W-1:0] period_o;
    logic [W-1:0] high_o;
    logic         valid_o;
    logic         idle_o;

    typedef struct {
        int p;
        int h;
        int c;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   armed = 1'b0;
    int   prev_p = 0;
    int   prev_h = 0;
    bit   last_valid = 1'b0;

    pwm_pitch_meter #(.CNT_W(W)) dut (
        .clk      (tb_clk),
        .RST      (RST),
        .pwm_i    (pwm_i),
        .period_o (period_o),
        .high_o   (high_o),
        .valid_o  (valid_o),
        .idle_o   (idle_o)
    );

    always #5 tb_clk = ~tb_clk;

    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Drive one cycle of pwm_i just after the clock edge; a rising drive queues the
    // measurement of the period that it closes.
    task automatic step(input logic v);
        exp_t e;
        @(posedge tb_clk);
        #1;
        if (v && !pwm_i) begin
            if (armed) begin
                e.p = prev_p;
                e.h = prev_h;
                e.c = cyc + 3;
                sb_q.push_back(e);
            end
            armed = 1'b1;
        end
        pwm_i = v;
    endtask

    task automatic run_wave(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < per; j++) begin
                step(j < hi);
                if (j == 0) begin
                    prev_p = per;
                    prev_h = hi;
                end
            end
        end
    endtask

    task automatic hold_low(input int n);
        for (int j = 0; j < n; j++) step(1'b0);
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge tb_clk) begin
        exp_t e;
        if (valid_o === 1'b1) begin
            chk("valid_gap", last_valid, 0);
            chk("idle_on_valid", idle_o, 0);
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("period", period_o, e.p);
                chk("high", high_o, e.h);
                chk("latency", cyc, e.c);
            end
        end
        last_valid = (valid_o === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a toggling input.
        for (int j = 0; j < 2; j++) begin
            @(posedge tb_clk);
            #1;
            pwm_i = ~pwm_i;
            @(negedge tb_clk);
            chk("rst_period", period_o, 0);
            chk("rst_high", high_o, 0);
            chk("rst_valid", valid_o, 0);
            chk("rst_idle", idle_o, 1);
        end
        @(posedge tb_clk);
        #1;
        pwm_i = 1'b0;
        RST = 1'b0;
        @(negedge tb_clk);
        chk("post_rst_period", period_o, 0);
        chk("post_rst_valid", valid_o, 0);
        chk("post_rst_idle", idle_o, 1);
        hold_low(4);

        run_wave(100, 50, 4);
        chk("steady_idle", idle_o, 0);
        run_wave(10, 1, 4);
        run_wave(2, 1, 4);
        run_wave(TMAX, TMAX / 2, 2);
        run_wave(100, 50, 2);

        // Loss of signal: still tracking below the limit, idle once past it.
        hold_low(3000);
        chk("pre_timeout_idle", idle_o, 0);
        hold_low(2000);
        chk("timeout_idle", idle_o, 1);
        chk("timeout_period_hold", period_o, 100);
        chk("timeout_high_hold", high_o, 50);
        armed = 1'b0;
        run_wave(100, 50, 3);

        // Reset halfway through a period.
        for (int j = 0; j < 50; j++) step(1'b1);
        @(posedge tb_clk);
        #1;
        pwm_i = 1'b0;
        RST = 1'b1;
        hold_low(1);
        @(posedge tb_clk);
        #1;
        RST = 1'b0;
        armed = 1'b0;
        @(negedge tb_clk);
        chk("midrst_idle", idle_o, 1);
        chk("midrst_period", period_o, 0);
        chk("midrst_high", high_o, 0);
        hold_low(46);
        run_wave(100, 50, 3);

        step(1'b1);
        hold_low(10);
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
